tx_framer: RTL and testbench
============================

# tx_framer

Serial HDLC transmit framer directly downstream of the TX buffer. When the buffer reports a frame available, the block:
- reads the frame one byte at a time (`RdBuff`/`DataOutBuff` handshake);
- wraps it in opening and closing flags;
- performs zero-bit insertion and shifts it out LSB first, one bit per clock.

It also generates the abort sequence and reports aborted transmissions back to the buffer.

## Interface
- No parameters; constants live in the shared package.
- `Clk`  in  1  clock; all state changes on rising edge.
- `Rst`  in  1  asynchronous, active-low reset.
- `DataAvail`  in  1  TX buffer holds a complete frame ready to send.
- `DataOutBuff`  in  8  byte currently presented by the TX buffer.
- `FrameSize`  in  8  number of bytes in the frame (0–128); sampled at frame start.
- `AbortFrame`  in  1  request to abort the frame in progress (level, sampled each cycle).
- `RdBuff`  out  1  one-cycle pulse; the byte on `DataOutBuff` is consumed this cycle.
- `AbortedTrans`  out  1  one-cycle pulse when an abort is accepted.
- `Tx`  out  1  registered serial line output.
- `TxBusy`  out  1  high from frame start until the closing flag or abort pattern completes.

## Operation
States:
- **IDLE** – outputs the idle pattern.
  - Leaves for **OPEN** when `DataAvail`=1. With `IDLE_FLAG_EN`, this happens only at an idle-flag byte boundary.
  - `FrameSize` is latched into an internal byte counter on that transition.
- **OPEN** – shifts out flag 0x7E with no stuffing.
  - On the last bit cycle: if counter > 0, pulse `RdBuff` and load `DataOutBuff` into the shift register, then go to **DATA**.
  - Otherwise go to **CLOSE**.
- **DATA** – shifts out data LSB first with zero insertion.
  - After five consecutive 1s, a 0 is inserted. The shift register holds for that cycle, and the ones counter clears.
  - The ones counter also clears on every transmitted 0.
  - After bit 7 of a byte is sent, decrement the counter. If counter > 0, pulse `RdBuff` and load the next byte in the same cycle; otherwise go to **CLOSE**.
  - A stuffed 0 pending after bit 7 is emitted before the next byte or the closing flag.
- **CLOSE** – shifts out 0x7E unstuffed, then returns to **IDLE**.
- **ABORT** – shifts out 0xFE LSB first (0 then seven 1s), unstuffed, then returns to **IDLE**.

Abort handling:
- `AbortFrame`=1 in **OPEN**, **DATA** or **CLOSE** is accepted on that edge.
- On acceptance: `AbortedTrans` pulses for one cycle, the ones counter clears, no further `RdBuff` pulses occur, and the next `Tx` bit is the first abort bit.
- `AbortFrame` in **IDLE** or **ABORT** is ignored.

Other rules:
- `DataAvail` dropping mid-frame has no effect; the frame is bounded by the latched `FrameSize` only.
- `RdBuff` pulses exactly `FrameSize` times per completed frame, and never in the same cycle as `AbortedTrans`.

## Timing
- Reset values: `Tx`=1, `RdBuff`=0, `AbortedTrans`=0, `TxBusy`=0; state **IDLE**; all counters 0. Reset mid-frame returns immediately to these values.
- Start latency, without `IDLE_FLAG_EN`: `DataAvail` sampled high at edge N → first opening-flag bit on `Tx` after edge N+1.
- `TxBusy` rises on the edge that enters **OPEN** and falls on the edge that enters **IDLE**.
- `RdBuff` is combinational from state and counters and is asserted during the cycle before the loaded byte's bit 0 appears on `Tx`.
- Line throughput is one bit per clock. A frame of N bytes with k stuffed zeros occupies exactly 16 + 8N + k bit cycles.

## Configuration
- Macro: `TX_FRAMER_IDLE_FLAG_EN`.
- Defined:
  - Idle pattern is continuous 0x7E flags.
  - Frame start waits for the current idle flag to finish.
  - The closing flag runs straight into idle flags.
- Undefined:
  - Idle pattern is constant 1 (mark idle).
  - Frame start is taken on the next edge.

## Structure
- Package `hdlc_pkg` holds:
  - `HDLC_FLAG` = 8'h7E;
  - `HDLC_ABORT` = 8'hFE;
  - `HDLC_MAX_FRAME` = 128;
  - the `tx_framer_state_t` enum (IDLE, OPEN, DATA, CLOSE, ABORT).
- One sub-module is natural: `tx_zero_insert`. It contains the ones counter and insert decision, with inputs for bit, valid and bypass, and outputs for the bit and a stall signal.

## Test plan
- Reset with `DataAvail`=1 held → `Tx`=1, `TxBusy`=0 and no `RdBuff` while `Rst`=0; after release, the frame starts.
- `FrameSize`=1, byte 0xFF → `Tx` = 0111 1110, 1111 1011 1, 0111 1110. The stream is 25 bits, one `RdBuff` pulse.
- `FrameSize`=0 → two back-to-back flags (16 bits) and zero `RdBuff` pulses.
- `FrameSize`=3, bytes 0x7E, 0x00, 0x3F → check insertion across byte boundaries. Exactly 3 `RdBuff` pulses, and the total length equals 40 + inserted zeros.
- `AbortFrame` during byte 2 of a 4-byte frame → `AbortedTrans` pulses once, then `Tx` = 0,1,1,1,1,1,1,1. `RdBuff` count is 2, then **IDLE**.
- Idle behaviour, with and without `TX_FRAMER_IDLE_FLAG_EN` → check repeated 0x7E versus constant 1, and the start alignment to the flag boundary.

Source files
------------

// File: rtl/hdlc_pkg.sv
// Shared HDLC constants and the transmit framer state type.
package hdlc_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned BIT_CNT_W = 3;
  localparam int unsigned ONES_W    = 3;

  localparam logic [BYTE_W-1:0] HDLC_FLAG      = 8'h7E;
  localparam logic [BYTE_W-1:0] HDLC_ABORT     = 8'hFE;
  localparam int unsigned       HDLC_MAX_FRAME = 128;

  // Run of consecutive ones after which a zero must be inserted.
  localparam logic [ONES_W-1:0] STUFF_RUN = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    OPEN,
    DATA,
    CLOSE,
    ABORT
  } tx_framer_state_t;

endpackage

// File: rtl/tx_zero_insert.sv
// Zero-bit insertion: counts consecutive ones on the line and forces a
// stuffed 0 (stalling the source) after five of them.
module tx_zero_insert
  import hdlc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic data_bit,
  input  logic valid,
  input  logic bypass,
  input  logic clear,
  output logic line_bit_c,
  output logic stall_c,
  output logic pend_c
);

  logic [ONES_W-1:0] ones;

  // pend_c flags that the current bit completes a run, so a stuffed 0 follows.
  always_comb begin
    stall_c    = valid && !bypass && (ones == STUFF_RUN);
    line_bit_c = stall_c ? 1'b0 : data_bit;
    pend_c     = valid && !bypass && !stall_c && data_bit &&
                 (ones == STUFF_RUN - ONES_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones <= '0;
    end else if (clear || (valid && (bypass || !line_bit_c))) begin
      ones <= '0;
    end else if (valid) begin
      ones <= ones + ONES_W'(1);
    end
  end

endmodule

// File: rtl/tx_framer.sv
// HDLC transmit framer: flags, zero insertion, LSB-first serialisation, abort.
// Optional feature macro: TX_FRAMER_IDLE_FLAG_EN (idle flags instead of mark idle).
module tx_framer
  import hdlc_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  input  logic              DataAvail,
  input  logic [BYTE_W-1:0] DataOutBuff,
  input  logic [CNT_W-1:0]  FrameSize,
  input  logic              AbortFrame,
  output logic              RdBuff,
  output logic              AbortedTrans,
  output logic              Tx,
  output logic              TxBusy
);

  tx_framer_state_t     state, state_nxt;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [CNT_W-1:0]     byte_cnt, byte_cnt_nxt;
  logic [BYTE_W-1:0]    shreg, shreg_nxt;
  logic                 tx_nxt;
  logic                 aborted_nxt;
  logic                 last_bit;
  logic                 abort_ok;
  logic                 zi_valid, zi_bypass, zi_clear;
  logic                 zi_bit, zi_stall, zi_pend;

  assign last_bit = (bit_cnt == BIT_CNT_W'(7));
  assign abort_ok = AbortFrame && ((state == OPEN) || (state == DATA) || (state == CLOSE));

  tx_zero_insert u_zero_insert (
    .clk        (Clk),
    .rst_n      (Rst),
    .data_bit   (shreg[0]),
    .valid      (zi_valid),
    .bypass     (zi_bypass),
    .clear      (zi_clear),
    .line_bit_c (zi_bit),
    .stall_c    (zi_stall),
    .pend_c     (zi_pend)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state, next line bit and byte-fetch handshake.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    byte_cnt_nxt = byte_cnt;
    shreg_nxt    = shreg;
    tx_nxt       = 1'b1;
    aborted_nxt  = 1'b0;
    RdBuff       = 1'b0;
    zi_valid     = 1'b0;
    zi_bypass    = 1'b1;
    zi_clear     = 1'b0;

    case (state)
      IDLE: begin
`ifdef TX_FRAMER_IDLE_FLAG_EN
        tx_nxt      = HDLC_FLAG[bit_cnt];
        bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
        if (DataAvail && last_bit) begin
          state_nxt    = OPEN;
          byte_cnt_nxt = FrameSize;
        end
`else
        bit_cnt_nxt = '0;
        if (DataAvail) begin
          state_nxt    = OPEN;
          byte_cnt_nxt = FrameSize;
        end
`endif
      end

      OPEN: begin
        tx_nxt      = HDLC_FLAG[bit_cnt];
        zi_valid    = 1'b1;
        bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
        if (last_bit) begin
          if (byte_cnt != '0) begin
            RdBuff    = 1'b1;
            shreg_nxt = DataOutBuff;
            state_nxt = DATA;
          end else begin
            state_nxt = CLOSE;
          end
        end
      end

      // byte_cnt == 0 inside DATA means only a trailing stuffed zero remains.
      DATA: begin
        zi_valid  = 1'b1;
        zi_bypass = 1'b0;
        tx_nxt    = zi_bit;
        if (zi_stall) begin
          if (byte_cnt == '0) begin
            state_nxt   = CLOSE;
            bit_cnt_nxt = '0;
          end
        end else begin
          shreg_nxt   = shreg >> 1;
          bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
          if (last_bit) begin
            byte_cnt_nxt = byte_cnt - CNT_W'(1);
            if (byte_cnt > CNT_W'(1)) begin
              RdBuff    = 1'b1;
              shreg_nxt = DataOutBuff;
            end else if (!zi_pend) begin
              state_nxt = CLOSE;
            end
          end
        end
      end

      CLOSE: begin
        tx_nxt      = HDLC_FLAG[bit_cnt];
        zi_valid    = 1'b1;
        bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
        if (last_bit) state_nxt = IDLE;
      end

      ABORT: begin
        tx_nxt      = HDLC_ABORT[bit_cnt];
        zi_valid    = 1'b1;
        bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
        if (last_bit) state_nxt = IDLE;
      end

      default: begin
        state_nxt   = IDLE;
        bit_cnt_nxt = '0;
      end
    endcase

    // Accepted abort: first abort bit goes out on this edge, the rest follow.
    if (abort_ok) begin
      state_nxt    = ABORT;
      bit_cnt_nxt  = BIT_CNT_W'(1);
      byte_cnt_nxt = '0;
      shreg_nxt    = shreg;
      tx_nxt       = HDLC_ABORT[0];
      aborted_nxt  = 1'b1;
      RdBuff       = 1'b0;
      zi_clear     = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      bit_cnt      <= '0;
      byte_cnt     <= '0;
      shreg        <= '0;
      Tx           <= 1'b1;
      AbortedTrans <= 1'b0;
      TxBusy       <= 1'b0;
    end else begin
      bit_cnt      <= bit_cnt_nxt;
      byte_cnt     <= byte_cnt_nxt;
      shreg        <= shreg_nxt;
      Tx           <= tx_nxt;
      AbortedTrans <= aborted_nxt;
      TxBusy       <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_tx_framer.sv
// Self-checking bench for tx_framer: bit-stream model plus literal pins.
// Idle checks follow TX_FRAMER_IDLE_FLAG_EN when it is defined.
module tb_tx_framer;

  localparam logic [7:0] FLAG      = 8'h7E;
  localparam logic [7:0] ABORT_PAT = 8'hFE;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       DataAvail = 1'b0;
  logic       AbortFrame = 1'b0;
  logic [7:0] FrameSize = 8'd0;
  logic [7:0] DataOutBuff;
  logic       RdBuff, AbortedTrans, Tx, TxBusy;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] frame [0:15];
  int         rd_idx;
  int         rd_base = 0;
  bit         exp_q[$];
  int         read_at[$];

  always #5 Clk = ~Clk;

  tx_framer dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .DataAvail    (DataAvail),
    .DataOutBuff  (DataOutBuff),
    .FrameSize    (FrameSize),
    .AbortFrame   (AbortFrame),
    .RdBuff       (RdBuff),
    .AbortedTrans (AbortedTrans),
    .Tx           (Tx),
    .TxBusy       (TxBusy)
  );

  // Buffer model: presents the next unread byte, advances on each RdBuff.
  always_comb DataOutBuff = frame[4'(rd_idx - rd_base)];

  always @(posedge Clk or negedge Rst) begin
    if (!Rst)        rd_idx <= 0;
    else if (RdBuff) rd_idx <= rd_idx + 1;
  end

  task automatic check(input string name, input logic [63:0] got_v, input logic [63:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got_v, exp_v);
    end
  endtask

  task automatic load(input logic [39:0] bytes);
    for (int i = 0; i < 5; i++) frame[i] = bytes[8*i +: 8];
  endtask

  // Expected line stream: flag, stuffed data, flag; abort truncates at bit j.
  task automatic build_model(input int n, input int abort_j);
    int ones;
    int last7;
    exp_q.delete();
    read_at.delete();
    ones  = 0;
    last7 = 0;
    for (int i = 0; i < 8; i++) exp_q.push_back(FLAG[i]);
    for (int b = 0; b < n; b++) begin
      read_at.push_back(b == 0 ? 7 : last7);
      for (int i = 0; i < 8; i++) begin
        exp_q.push_back(frame[b][i]);
        ones = frame[b][i] ? ones + 1 : 0;
        if (i == 7) last7 = exp_q.size() - 1;
        if (ones == 5) begin
          exp_q.push_back(1'b0);
          ones = 0;
        end
      end
    end
    for (int i = 0; i < 8; i++) exp_q.push_back(FLAG[i]);
    if (abort_j >= 0) begin
      while (exp_q.size() > abort_j) void'(exp_q.pop_back());
      for (int i = 0; i < 8; i++) exp_q.push_back(ABORT_PAT[i]);
    end
  endtask

  // Call at a negedge; returns at the negedge showing the last frame bit.
  task automatic run_frame(input string tag, input int n, input int abort_j,
                           input int lit_len, input logic [63:0] lit);
    int L, k, rd0, exp_rd;
    logic [63:0] got, mask;
    build_model(n, abort_j);
    L = exp_q.size();
    exp_rd = 0;
    foreach (read_at[r]) if (abort_j < 0 || read_at[r] < abort_j) exp_rd++;
    got = '0;
    rd0 = rd_idx;
    rd_base = rd_idx;
    DataAvail = 1'b1;
    FrameSize = 8'(n);
    k = 0;
    while (!TxBusy && k < 20) begin
      @(negedge Clk);
      k++;
    end
    DataAvail = 1'b0;
    check($sformatf("%s start_seen", tag), 64'(k < 20), 64'd1);
    if (k >= 20) return;
`ifndef TX_FRAMER_IDLE_FLAG_EN
    check($sformatf("%s start_latency", tag), 64'(k), 64'd1);
`endif
    for (int i = 0; i < L; i++) begin
      @(negedge Clk);
      got = {got[62:0], Tx};
      check($sformatf("%s tx_bit%0d", tag, i), 64'(Tx), 64'(exp_q[i]));
      check($sformatf("%s busy%0d", tag, i), 64'(TxBusy), 64'(i < L - 1));
      check($sformatf("%s aborted%0d", tag, i), 64'(AbortedTrans),
            64'(abort_j >= 0 && i == abort_j));
      AbortFrame = (abort_j >= 0 && i == abort_j - 1);
    end
    AbortFrame = 1'b0;
    check($sformatf("%s rd_count", tag), 64'(rd_idx - rd0), 64'(exp_rd));
    if (lit_len > 0) begin
      mask = (64'd1 << lit_len) - 64'd1;
      check($sformatf("%s model_len", tag), 64'(L), 64'(lit_len));
      check($sformatf("%s literal_stream", tag), got & mask, lit);
    end
  endtask

  // Idle line with a stray AbortFrame, which must be ignored.
  task automatic idle_check(input string tag);
    int rd0;
    rd0 = rd_idx;
    for (int c = 0; c < 12; c++) begin
      AbortFrame = (c == 3);
      @(negedge Clk);
`ifdef TX_FRAMER_IDLE_FLAG_EN
      check($sformatf("%s idle_tx%0d", tag, c), 64'(Tx), 64'(FLAG[c % 8]));
`else
      check($sformatf("%s idle_tx%0d", tag, c), 64'(Tx), 64'd1);
`endif
      check($sformatf("%s idle_busy%0d", tag, c), 64'(TxBusy), 64'd0);
      check($sformatf("%s idle_aborted%0d", tag, c), 64'(AbortedTrans), 64'd0);
    end
    AbortFrame = 1'b0;
    check($sformatf("%s idle_rd", tag), 64'(rd_idx - rd0), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset held with a frame pending.
    load(40'h00_0000_00FF);
    DataAvail = 1'b1;
    FrameSize = 8'd1;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      check($sformatf("reset tx%0d", c), 64'(Tx), 64'd1);
      check($sformatf("reset busy%0d", c), 64'(TxBusy), 64'd0);
      check($sformatf("reset rdbuff%0d", c), 64'(RdBuff), 64'd0);
      check($sformatf("reset aborted%0d", c), 64'(AbortedTrans), 64'd0);
    end
    Rst = 1'b1;
    run_frame("ff", 1, -1, 25, 64'({8'b01111110, 9'b111110111, 8'b01111110}));
    idle_check("ff");

    run_frame("empty", 0, -1, 16, 64'({8'b01111110, 8'b01111110}));
    idle_check("empty");

    load(40'h00_003F_007E);
    run_frame("three", 3, -1, 42,
              64'({8'b01111110, 9'b011111010, 8'b00000000, 9'b111110100, 8'b01111110}));
    idle_check("three");

    load(40'h00_F8);
    run_frame("tailstuff", 1, -1, 25, 64'({8'b01111110, 9'b000111110, 8'b01111110}));
    idle_check("tailstuff");

    load(40'h00_C3A5_0F55);
    run_frame("abort_data", 4, 19, 27,
              64'({8'b01111110, 8'b10101010, 3'b111, 8'b01111111}));
    idle_check("abort_data");

    load(40'hF8_7FFF_0FF0);
    run_frame("five", 5, -1, 0, 64'd0);
    idle_check("five");

    load(40'h00_0000_1122);
    run_frame("abort_open", 2, 3, 0, 64'd0);
    idle_check("abort_open");

    run_frame("abort_close", 0, 12, 0, 64'd0);
    idle_check("abort_close");

    // Reset in the middle of a frame.
    load(40'h00_0000_FF81);
    rd_base = rd_idx;
    DataAvail = 1'b1;
    FrameSize = 8'd2;
    repeat (14) @(negedge Clk);
    DataAvail = 1'b0;
    Rst = 1'b0;
    #1;
    check("midreset tx", 64'(Tx), 64'd1);
    check("midreset busy", 64'(TxBusy), 64'd0);
    check("midreset rdbuff", 64'(RdBuff), 64'd0);
    check("midreset aborted", 64'(AbortedTrans), 64'd0);
    @(negedge Clk);
    Rst = 1'b1;
    idle_check("midreset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
